// File: rtl/tl45_bus_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter. Master B (data stage) has
// priority; a starvation counter forces a grant to master A (fetch) after MAX_CONSEC B wins.
module tl45_bus_arbiter #(
  parameter int unsigned AW         = 30,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_stall,
  output logic          o_a_ack,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic [3:0] MaxConsec = 4'(MAX_CONSEC);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grants are only issued from IDLE, so owners are always separated by one idle cycle.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (i_b_cyc && !(i_a_cyc && (starve_q >= MaxConsec))) begin
          state_d = OWN_B;
          if (!i_a_cyc)
            starve_d = '0;
          else if (starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
        end else if (i_a_cyc) begin
          state_d  = OWN_A;
          starve_d = '0;
        end
      end
      OWN_A: if (!i_a_cyc) state_d = IDLE;
      OWN_B: if (!i_b_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_rdata = i_wb_data;

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    case (state_q)
      OWN_A: begin
        o_wb_cyc  = i_a_cyc;
        o_wb_stb  = i_a_stb;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_a_stall = i_wb_stall;
        o_a_ack   = i_wb_ack;
      end
      OWN_B: begin
        o_wb_cyc  = i_b_cyc;
        o_wb_stb  = i_b_stb;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_b_stall = i_wb_stall;
        o_b_ack   = i_wb_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tl45_bus_arbiter.sv
// Directed bench for tl45_bus_arbiter: a scoreboard queue holds expected acks,
// a negedge monitor matches every forwarded ack against it.
module tb_tl45_bus_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [DW-1:0] i_a_data;
  logic          o_a_stall, o_a_ack;
  logic          i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [DW-1:0] i_b_data;
  logic          o_b_stall, o_b_ack;
  logic [DW-1:0] o_rdata;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_stall, i_wb_ack;
  logic [DW-1:0] i_wb_data;

  tl45_bus_arbiter #(.AW(AW), .DW(DW), .MAX_CONSEC(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack),
    .o_rdata(o_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          to_b;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge i_clk);
  endtask

  // Owner check: which master sees the bus (stall released) and o_wb_cyc
  task automatic chk_owner(input string name, input bit own_b);
    chk({name, "_cyc"}, 64'(o_wb_cyc), 64'd1);
    chk({name, "_a_stall"}, 64'(o_a_stall), 64'(own_b));
    chk({name, "_b_stall"}, 64'(o_b_stall), 64'(!own_b));
  endtask

  always @(negedge i_clk) begin
    if (o_a_ack && o_b_ack) begin
      chk("both_acks", 64'd1, 64'd0);
    end else if (o_a_ack || o_b_ack) begin
      if (sb.size() == 0) begin
        chk(o_a_ack ? "unexpected_a_ack" : "unexpected_b_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_to_b", 64'(o_b_ack), 64'(e.to_b));
        chk("ack_rdata", 64'(o_rdata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit own_b_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    i_reset = 1'b1;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_data = '0;
    tick(); tick();
    i_reset = 1'b0;
    at_neg();
    chk("rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
    chk("rst_wb_stb", 64'(o_wb_stb), 64'd0);
    chk("rst_wb_we", 64'(o_wb_we), 64'd0);
    chk("rst_wb_addr", 64'(o_wb_addr), 64'd0);
    chk("rst_wb_data", 64'(o_wb_data), 64'd0);
    chk("rst_a_stall", 64'(o_a_stall), 64'd1);
    chk("rst_b_stall", 64'(o_b_stall), 64'd1);

    // 1: A only read of 0x100
    tick();
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h100;
    at_neg();
    chk("t1_cyc_not_yet", 64'(o_wb_cyc), 64'd0);
    tick();
    at_neg();
    chk_owner("t1_grant", 1'b0);
    chk("t1_stb", 64'(o_wb_stb), 64'd1);
    chk("t1_addr", 64'(o_wb_addr), 64'h100);
    tick();
    i_a_stb = 0; i_wb_ack = 1; i_wb_data = 32'hDEADBEEF;
    e.to_b = 0; e.data = 32'hDEADBEEF; sb.push_back(e);
    tick();
    i_wb_ack = 0; i_a_cyc = 0;
    at_neg();
    chk("t1_cyc_drop", 64'(o_wb_cyc), 64'd0);
    tick();

    // 2: simultaneous requests, B first, one idle cycle, then A
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h200;
    i_b_cyc = 1; i_b_stb = 1; i_b_we = 1; i_b_addr = 30'h300; i_b_data = 32'hCAFE;
    tick();
    at_neg();
    chk_owner("t2_grant_b", 1'b1);
    chk("t2_addr_b", 64'(o_wb_addr), 64'h300);
    tick();
    i_b_stb = 0; i_wb_ack = 1; i_wb_data = 32'h0;
    e.to_b = 1; e.data = 32'h0; sb.push_back(e);
    at_neg();
    chk("t2_a_stall_mid", 64'(o_a_stall), 64'd1);
    tick();
    i_wb_ack = 0; i_b_cyc = 0; i_b_we = 0;
    tick();
    at_neg();
    chk("t2_idle_cyc", 64'(o_wb_cyc), 64'd0);
    chk("t2_idle_a_stall", 64'(o_a_stall), 64'd1);
    tick();
    at_neg();
    chk_owner("t2_grant_a", 1'b0);
    chk("t2_addr_a", 64'(o_wb_addr), 64'h200);
    tick();
    i_a_stb = 0; i_wb_ack = 1; i_wb_data = 32'h11;
    e.to_b = 0; e.data = 32'h11; sb.push_back(e);
    tick();
    i_wb_ack = 0; i_a_cyc = 0;
    tick();

    // 3: starvation guard with MAX_CONSEC=2, expected grants B,B,A,B,B
    i_a_cyc = 1; i_b_cyc = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      at_neg();
      chk_owner($sformatf("t3_grant%0d", k), own_b_seq[k]);
      tick();
      if (own_b_seq[k]) i_b_cyc = 0; else i_a_cyc = 0;
      tick();
      i_a_cyc = 1; i_b_cyc = 1;
      at_neg();
      chk($sformatf("t3_idle%0d", k), 64'(o_wb_cyc), 64'd0);
    end
    tick();
    i_a_cyc = 0; i_b_cyc = 0;
    tick();
    tick();

    // 4: B write stalled for 3 cycles
    i_b_cyc = 1; i_b_stb = 1; i_b_we = 1; i_b_addr = 30'h40; i_b_data = 32'h12345678;
    i_wb_stall = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("t4_b_stall%0d", k), 64'(o_b_stall), 64'd1);
      chk($sformatf("t4_addr%0d", k), 64'(o_wb_addr), 64'h40);
      chk($sformatf("t4_data%0d", k), 64'(o_wb_data), 64'h12345678);
      chk($sformatf("t4_we%0d", k), 64'(o_wb_we), 64'd1);
      tick();
    end
    i_wb_stall = 0;
    at_neg();
    chk("t4_b_stall_rel", 64'(o_b_stall), 64'd0);
    tick();
    i_b_stb = 0; i_wb_ack = 1; i_wb_data = 32'h0;
    e.to_b = 1; e.data = 32'h0; sb.push_back(e);
    tick();
    i_wb_ack = 0; i_b_cyc = 0; i_b_we = 0;
    tick();

    // 5: reset while A owns the bus with an ack outstanding
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h500;
    tick();
    at_neg();
    chk_owner("t5_grant_a", 1'b0);
    tick();
    i_a_stb = 0; i_reset = 1;
    tick();
    i_reset = 0; i_wb_ack = 1; i_wb_data = 32'h55;
    at_neg();
    chk("t5_cyc", 64'(o_wb_cyc), 64'd0);
    chk("t5_a_stall", 64'(o_a_stall), 64'd1);
    chk("t5_b_stall", 64'(o_b_stall), 64'd1);
    chk("t5_a_ack", 64'(o_a_ack), 64'd0);
    tick();
    i_wb_ack = 0; i_a_cyc = 0;
    tick();
    tick();

    // 6: B abandons, slave acks in IDLE, pending A then granted
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 30'h600;
    tick();
    at_neg();
    chk_owner("t6_grant_b", 1'b1);
    tick();
    i_b_stb = 0; i_b_cyc = 0; i_a_cyc = 1;
    at_neg();
    chk("t6_cyc_abort", 64'(o_wb_cyc), 64'd0);
    tick();
    i_wb_ack = 1; i_wb_data = 32'hBAD;
    at_neg();
    chk("t6_b_ack_idle", 64'(o_b_ack), 64'd0);
    chk("t6_a_ack_idle", 64'(o_a_ack), 64'd0);
    tick();
    i_wb_ack = 0;
    at_neg();
    chk_owner("t6_grant_a", 1'b0);
    tick();
    i_a_cyc = 0;
    tick();
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
